baud_tick_gen: RTL
==================

BAUD_TICK_GEN -- requirements
Module: baud_tick_gen

Interface
REQ-001 The block SHALL have parameter CLOCK_RATE, default 25000000, meaning input clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD_RATE, default 115200, meaning the reset-default line rate.
REQ-003 The block SHALL have parameter RX_OVERSAMPLE, default 16, meaning RX ticks per bit; legal values are even and at least 4.
REQ-004 The block SHALL have parameter DIV_WIDTH, default 16, meaning the width of the integer divisor.
REQ-005 The block SHALL have parameter FRAC_BITS, default 4, meaning the width of the fractional divisor.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 The block SHALL have port reset_n, input, 1 bit: reset that is asynchronous and active-low.
REQ-008 The block SHALL have port i_Enable, input, 1 bit: tick generation runs while it is high.
REQ-009 The block SHALL have port i_Sync, input, 1 bit: a single-cycle pulse that restarts the bit phase.
REQ-010 The block SHALL have port i_Div_Load, input, 1 bit: a single-cycle request to load a new divisor.
REQ-011 The block SHALL have port i_Div_Int, input, DIV_WIDTH bits: clocks per RX tick, integer part.
REQ-012 The block SHALL have port i_Div_Frac, input, FRAC_BITS bits: clocks per RX tick, fractional part, in units of 1/2^FRAC_BITS.
REQ-013 The block SHALL have port o_Rx_Tick, output, 1 bit: a single-cycle oversample strobe.
REQ-014 The block SHALL have port o_Mid_Tick, output, 1 bit: a single-cycle mid-bit sample strobe.
REQ-015 The block SHALL have port o_Tx_Tick, output, 1 bit: a single-cycle bit-boundary strobe.
REQ-016 The block SHALL have port o_Cfg_Err, output, 1 bit: high while the last load request was rejected.

Function
REQ-017 All outputs SHALL be registered, and every tick output SHALL be a one-clock pulse, never a toggled clock.
REQ-018 The active divisor SHALL be held as a pair (INT, FRAC), and the RX period SHALL be INT cycles, or INT+1 cycles when a fractional carry occurs.
REQ-019 The fractional rule SHALL be: at each RX tick, ACC <= (ACC+FRAC) mod 2^FRAC_BITS; the next period is lengthened by one cycle if that sum overflowed.
REQ-020 Over 2^FRAC_BITS consecutive RX periods, the total length SHALL equal exactly 2^FRAC_BITS*INT+FRAC cycles.
REQ-021 An oversample counter (0..RX_OVERSAMPLE-1) SHALL advance on each RX tick and wrap from RX_OVERSAMPLE-1 to 0.
REQ-022 o_Tx_Tick SHALL assert in the same cycle as the RX tick on which the oversample counter wraps.
REQ-023 o_Mid_Tick SHALL assert in the same cycle as the RX tick on which the oversample counter moves from RX_OVERSAMPLE/2-1 to RX_OVERSAMPLE/2.
REQ-024 The first o_Rx_Tick SHALL appear exactly INT cycles after the edge at which i_Enable is first sampled high.
REQ-025 While i_Enable is low: the period counter, ACC and oversample counter SHALL be held at 0, and all ticks SHALL be 0.
REQ-026 When i_Sync is sampled high with i_Enable high: the period counter, ACC and oversample counter SHALL clear, no tick SHALL be emitted that cycle, and the next RX tick SHALL follow exactly INT cycles later.
REQ-027 i_Sync SHALL override a tick that would otherwise occur in the same cycle.
REQ-028 A load request with i_Div_Int >= 2 SHALL be captured into a pending register and SHALL clear o_Cfg_Err on the next edge.
REQ-029 A load request with i_Div_Int < 2 SHALL be rejected: the divisor and any pending value are unchanged, and o_Cfg_Err SHALL be set on the next edge.
REQ-030 While enabled, a pending divisor SHALL become active at the next RX-tick boundary (or sync), so a period in flight is never shortened.
REQ-031 A load coincident with a tick or sync SHALL take effect at that same boundary.
REQ-032 While disabled, a load SHALL take effect on the next edge.
REQ-033 A later load SHALL overwrite an earlier pending load that has not yet been applied.
REQ-034 All counters SHALL be sized to hold their maximum value without overflow, and the period counter SHALL be DIV_WIDTH bits.

Reset
REQ-035 On reset_n low, asynchronously: all ticks SHALL be 0, o_Cfg_Err SHALL be 0, all counters and ACC SHALL be 0, and no load SHALL be pending.
REQ-036 On reset, INT SHALL be CLOCK_RATE/(BAUD_RATE*RX_OVERSAMPLE) truncated (clamped to a minimum of 2), and FRAC SHALL be 0.
REQ-037 Reset asserted mid-period SHALL abort the period, and ticks SHALL restart per REQ-024 after release.

Verification
REQ-038 Defaults, reset then i_Enable=1 -> o_Rx_Tick every 13 cycles, o_Tx_Tick every 208 cycles, o_Mid_Tick 104 cycles after each o_Tx_Tick, with first RX tick 13 cycles after enable.
REQ-039 Load INT=13, FRAC=9 -> over 16 RX periods, nine periods are 14 cycles and seven are 13 cycles, and Tx-to-Tx spacing is 217 cycles.
REQ-040 Load i_Div_Int=1 -> o_Cfg_Err=1 and the period stays at 13; then load INT=20 -> o_Cfg_Err=0 and the period becomes 20 starting at the next tick boundary.
REQ-041 i_Sync mid-bit (oversample count 7) -> no tick that cycle, next RX tick after exactly INT cycles, and o_Tx_Tick after 16*INT cycles.
REQ-042 i_Enable low for 50 cycles mid-bit -> no ticks; on re-enable the first RX tick comes after INT cycles, with the oversample count restarted from 0.
REQ-043 reset_n pulsed low for 1 cycle mid-period -> all outputs 0 immediately (asynchronously), divisor back to default, and REQ-038 timing holds afterwards.

Source files
------------

// File: rtl/baud_tick_gen.sv
// Fractional-divisor UART tick generator: RX oversample, mid-bit and TX bit-boundary strobes.
// The divisor can be reloaded at run time and takes effect only on a period boundary.
module baud_tick_gen #(
  parameter int CLOCK_RATE    = 25000000,
  parameter int BAUD_RATE     = 115200,
  parameter int RX_OVERSAMPLE = 16,
  parameter int DIV_WIDTH     = 16,
  parameter int FRAC_BITS     = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_Enable,
  input  logic                 i_Sync,
  input  logic                 i_Div_Load,
  input  logic [DIV_WIDTH-1:0] i_Div_Int,
  input  logic [FRAC_BITS-1:0] i_Div_Frac,
  output logic                 o_Rx_Tick,
  output logic                 o_Mid_Tick,
  output logic                 o_Tx_Tick,
  output logic                 o_Cfg_Err
);

  localparam int OS_W    = $clog2(RX_OVERSAMPLE);
  localparam int RAW_INT = CLOCK_RATE / (BAUD_RATE * RX_OVERSAMPLE);
  localparam logic [DIV_WIDTH-1:0] DEF_INT  = (RAW_INT < 2) ? DIV_WIDTH'(2) : DIV_WIDTH'(RAW_INT);
  localparam logic [OS_W-1:0]      OS_LAST  = OS_W'(RX_OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]      OS_PRE_MID = OS_W'(RX_OVERSAMPLE / 2 - 1);

  logic [DIV_WIDTH-1:0] period_cnt;
  logic [FRAC_BITS-1:0] acc;
  logic [OS_W-1:0]      os_cnt;
  logic                 extend;
  logic                 run;
  logic [DIV_WIDTH-1:0] div_int;
  logic [FRAC_BITS-1:0] div_frac;
  logic                 pend_valid;
  logic [DIV_WIDTH-1:0] pend_int;
  logic [FRAC_BITS-1:0] pend_frac;

  logic                 load_ok;
  logic                 load_bad;
  logic                 restart;
  logic                 period_end;
  logic [DIV_WIDTH:0]   cnt_inc;
  logic [DIV_WIDTH:0]   period_len;
  logic [DIV_WIDTH-1:0] nxt_int;
  logic [FRAC_BITS-1:0] nxt_frac;
  logic [FRAC_BITS:0]   frac_sum;

  assign load_ok  = i_Div_Load && (i_Div_Int >= DIV_WIDTH'(2));
  assign load_bad = i_Div_Load && !load_ok;

  // The first enabled edge after idle behaves like a sync, so the first tick lands INT cycles later.
  assign restart    = i_Enable && (!run || i_Sync);
  assign cnt_inc    = {1'b0, period_cnt} + {{DIV_WIDTH{1'b0}}, 1'b1};
  assign period_len = {1'b0, div_int} + {{DIV_WIDTH{1'b0}}, extend};
  assign period_end = i_Enable && run && !i_Sync && (cnt_inc == period_len);

  // Divisor for the next period: a load in the boundary cycle wins over an older pending one.
  assign nxt_int  = load_ok ? i_Div_Int  : (pend_valid ? pend_int  : div_int);
  assign nxt_frac = load_ok ? i_Div_Frac : (pend_valid ? pend_frac : div_frac);
  assign frac_sum = {1'b0, acc} + {1'b0, nxt_frac};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period_cnt <= '0;
      acc        <= '0;
      os_cnt     <= '0;
      extend     <= 1'b0;
      run        <= 1'b0;
      div_int    <= DEF_INT;
      div_frac   <= '0;
      pend_valid <= 1'b0;
      pend_int   <= '0;
      pend_frac  <= '0;
      o_Rx_Tick  <= 1'b0;
      o_Mid_Tick <= 1'b0;
      o_Tx_Tick  <= 1'b0;
      o_Cfg_Err  <= 1'b0;
    end else begin
      run        <= i_Enable;
      o_Rx_Tick  <= 1'b0;
      o_Mid_Tick <= 1'b0;
      o_Tx_Tick  <= 1'b0;

      if (load_ok) begin
        o_Cfg_Err <= 1'b0;
      end else if (load_bad) begin
        o_Cfg_Err <= 1'b1;
      end

      if (!i_Enable || restart) begin
        period_cnt <= '0;
        acc        <= '0;
        os_cnt     <= '0;
        extend     <= 1'b0;
        div_int    <= nxt_int;
        div_frac   <= nxt_frac;
        pend_valid <= 1'b0;
      end else if (period_end) begin
        period_cnt <= '0;
        acc        <= frac_sum[FRAC_BITS-1:0];
        extend     <= frac_sum[FRAC_BITS];
        os_cnt     <= (os_cnt == OS_LAST) ? '0 : os_cnt + OS_W'(1);
        o_Rx_Tick  <= 1'b1;
        o_Tx_Tick  <= (os_cnt == OS_LAST);
        o_Mid_Tick <= (os_cnt == OS_PRE_MID);
        div_int    <= nxt_int;
        div_frac   <= nxt_frac;
        pend_valid <= 1'b0;
      end else begin
        period_cnt <= cnt_inc[DIV_WIDTH-1:0];
        if (load_ok) begin
          pend_valid <= 1'b1;
          pend_int   <= i_Div_Int;
          pend_frac  <= i_Div_Frac;
        end
      end
    end
  end

endmodule
